// File: rtl/mux_sel_skid.sv
// mux_sel_skid: clamped channel select feeding a two-entry skid buffer (output + skid register).
module mux_sel_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(NUM_IN - 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] oreg, sreg, sel_d;
  logic [SEL_WIDTH-1:0] osel, ssel, sel_c;
  logic acc, xfer, load_o, load_s, o_from_s;
  assign sel_c = (sel > MAX_SEL) ? MAX_SEL : sel;
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (sel_c == SEL_WIDTH'(i)) sel_d = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign in_ready  = (state != FULL) && !flush && !reset;
  assign out_valid = state != EMPTY;
  assign out_data  = oreg;
  assign out_sel   = osel;
  assign count     = state;
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  always_comb begin
    state_n  = state;
    load_o   = 1'b0;
    load_s   = 1'b0;
    o_from_s = 1'b0;
    if (flush) state_n = EMPTY;
    else
      case (state)
        EMPTY: begin
          load_o  = acc;
          state_n = acc ? ONE : EMPTY;
        end
        ONE: begin
          load_o  = acc && xfer;
          load_s  = acc && !xfer;
          state_n = (acc && !xfer) ? FULL : (!acc && xfer) ? EMPTY : ONE;
        end
        FULL: begin
          o_from_s = xfer;
          state_n  = xfer ? ONE : FULL;
        end
        default: state_n = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      oreg  <= '0;
      osel  <= '0;
      sreg  <= '0;
      ssel  <= '0;
    end else begin
      state <= state_n;
      if (load_o) begin
        oreg <= sel_d;
        osel <= sel_c;
      end else if (o_from_s) begin
        oreg <= sreg;
        osel <= ssel;
      end
      if (load_s) begin
        sreg <= sel_d;
        ssel <= sel_c;
      end
    end
  end
endmodule

// File: doc/mux_sel_skid.md
MUX_SEL_SKID -- requirements
Module: mux_sel_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each input channel and of out_data.
REQ-002 SHALL have parameter NUM_IN, default 3, legal range 2..8: number of input channels.
REQ-003 SHALL have parameter SEL_WIDTH, default 2: width of sel; must be >= ceil(log2(NUM_IN)).
REQ-004 SHALL provide the following ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*DATA_WIDTH  flattened channels; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- sel  input  SEL_WIDTH  channel select, sampled with in_data.
- in_valid  input  1  upstream offers a word.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  discard all buffered words.
- out_data  output  DATA_WIDTH  registered selected word.
- out_sel  output  SEL_WIDTH  sel value that produced out_data, after clamping.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  2  occupancy, 0..2.

Function
REQ-005 Selected word SHALL be channel sel when sel < NUM_IN, else channel NUM_IN-1 (clamp); out_sel SHALL carry the clamped index.
REQ-006 Accept SHALL occur on a rising edge where in_valid && in_ready; transfer out SHALL occur on a rising edge where out_valid && out_ready.
REQ-007 Storage SHALL be two entries: output register (OREG) and skid register (SREG), each holding data plus clamped sel.
REQ-008 SHALL implement three states: EMPTY (count 0), ONE (count 1, OREG valid), FULL (count 2, both valid).
REQ-009 in_ready SHALL be (state != FULL) && !flush && !reset; its only combinational inputs are flush and reset.
REQ-010 out_valid SHALL be 1 exactly in ONE and FULL; out_data/out_sel SHALL drive from OREG.
REQ-011 EMPTY: accept -> ONE, OREG loaded; otherwise stay.
REQ-012 ONE: accept with transfer out -> ONE, OREG reloaded; accept without transfer -> FULL, SREG loaded; transfer without accept -> EMPTY; neither -> stay.
REQ-013 FULL: transfer out -> ONE, OREG <= SREG; otherwise stay; no accept possible.
REQ-014 Latency SHALL be 1 cycle: a word accepted at edge k SHALL appear on out_data with out_valid=1 after edge k when the block was EMPTY or draining.
REQ-015 Sustained throughput SHALL be one word per cycle with in_valid and out_ready held high; no bubbles.
REQ-016 While out_valid && !out_ready, out_data and out_sel SHALL remain unchanged.
REQ-017 Words SHALL emerge in acceptance order; none dropped or duplicated except by flush or reset.
REQ-018 flush SHALL force next state EMPTY regardless of in_valid/out_ready; a word offered in the flush cycle is not accepted (in_ready=0); data register contents are don't-care once out_valid=0.
REQ-019 Simultaneous reset and flush: reset behaviour governs.

Reset
REQ-020 On a clock edge with reset=1: state EMPTY, out_valid 0, out_data 0, out_sel 0, count 0, SREG cleared; in_ready SHALL be 0 while reset is high and 1 in the first cycle after release.
REQ-021 Reset asserted in any state, including FULL mid-backpressure, SHALL discard all words with no output transfer.

Verification
REQ-022 NUM_IN=3, channels {0xA,0xB,0xC}, sel=1, in_valid=1, out_ready=1 for one cycle -> next cycle out_data=0xB, out_sel=1, out_valid=1, count=1.
REQ-023 NUM_IN=3, sel=3 with channel2=0xC -> out_data=0xC, out_sel=2.
REQ-024 out_ready=0, accept 0x11 then 0x22 -> count=2, in_ready=0, out_data held 0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles, count 2->1->0.
REQ-025 In FULL, assert flush with in_valid=1 and out_ready=0 -> next cycle out_valid=0, count=0, no word emitted, in_ready=1 the following cycle.
REQ-026 Stream 8 words 1..8, in_valid=out_ready=1 continuously -> outputs 1..8 on 8 consecutive cycles, count constant 1.
REQ-027 reset pulsed while FULL -> after edge out_valid=0, out_data=0, count=0; no stale word appears after release.
